l2_cache_arb_stage_mq: RTL and testbench
========================================

// Module: l2_cache_arb_stage_mq
// PURPOSE
//  Parametrised L2 request arbiter stage. Each core has its own request queue of FIFO_DEPTH.
//  A round-robin arbiter picks among queue heads. Restarted requests from l2_axi_bus_interface
//  always win. Feeds l2_cache_tag_stage.
//  l2_ready depends only on queue state, so cores may make valid depend on ready.
// PARAMETERS
//  NUM_REQUESTERS  4  core request channels (>=1)
//  FIFO_DEPTH      4  entries per request queue (power of 2, >=2)
// PORTS
//  clk                     in   1                   clock
//  reset                   in   1                   async reset, active high
//  l2i_request_valid       in   NUM_REQUESTERS      per-core request valid
//  l2i_request             in   l2req_packet_t[N]   per-core request packet
//  l2_ready                out  1 x N               queue i not full; push = valid[i] && ready[i]
//  l2bi_request_valid      in   1                   restarted request valid
//  l2bi_request            in   l2req_packet_t      restarted request
//  l2bi_data_from_memory   in   cache_line_data_t   fill data
//  l2bi_stall              in   1                   bus interface stall; blocks core issue
//  l2bi_collided_miss      in   1                   restarted request was a collided miss
//  l2a_request_valid       out  1                   request valid to tag stage
//  l2a_request             out  l2req_packet_t      issued request
//  l2a_data_from_memory    out  cache_line_data_t   registered copy of l2bi_data_from_memory
//  l2a_is_l2_fill          out  1                   issued request is an L2 fill
//  l2a_is_restarted_flush  out  1                   issued request is a restarted flush
//  perf_restart_preempt    out  1                   restart issued while a core queue was non-empty
// BEHAVIOUR
//  Reset, asynchronous:
//   - Queues empty, so l2_ready all 1.
//   - l2a_request_valid, l2a_is_l2_fill, l2a_is_restarted_flush and perf_restart_preempt are 0.
//   - RR pointer = NUM_REQUESTERS-1, so requester 0 has priority first.
//   - Reset mid-operation discards all queued requests.
//   - l2a_request and l2a_data_from_memory are not reset.
//  Queues:
//   - Push at the clock edge when valid[i] && ready[i].
//   - No bypass: a push is eligible for grant no earlier than the next cycle.
//   - Push and pop on the same queue in one cycle leaves its count unchanged.
//   - A push while full is an assertion error.
//  Issue, evaluated each cycle:
//   1. If l2bi_request_valid, the restart issues at the next edge:
//      - l2a_request = l2bi_request.
//      - l2a_is_l2_fill = !l2bi_collided_miss && type!=L2REQ_FLUSH.
//      - l2a_is_restarted_flush = (type==L2REQ_FLUSH).
//      - No queue pops.
//      - Assert type is not L2REQ_IINVALIDATE and not L2REQ_DINVALIDATE.
//   2. Else, if !l2bi_stall and any queue is non-empty:
//      - Grant the first non-empty queue after the RR pointer, modulo N.
//      - Pop that queue; l2a_request = its head; fill and flush flags = 0.
//      - The RR pointer moves to the granted index, and only on a pop.
//   3. Else l2a_request_valid = 0 at the next edge.
//  Timing and ordering:
//   - Minimum latency is 2 edges: a request pushed at edge N is seen at l2a_* after edge N+1.
//   - Requests from one core are issued in order.
//   - With no restarts or stalls, a non-empty queue is granted within NUM_REQUESTERS issue cycles.
//  Other outputs:
//   - l2a_data_from_memory is registered every cycle, unconditionally.
//   - perf_restart_preempt is registered: 1 for the cycle after a restart issues while any queue count is > 0.
//   - NUM_REQUESTERS==1: no RR; queue 0 is granted whenever it is non-empty.
// TESTING
//  - Reset, then a core 0 push at edge 0 -> l2a_request_valid=1 with that packet after edge 1;
//    l2_ready[0] stays 1.
//  - Core 2 pushes 4 requests with no pops (l2bi_stall=1) -> l2_ready[2]=0 after the 4th push.
//    Release stall -> 4 issues in push order, one per cycle.
//  - All 4 queues hold 2 entries each, no stalls -> grant order 0,1,2,3,0,1,2,3.
//  - Restart (FLUSH) valid while queues are non-empty:
//    - l2a_is_restarted_flush=1, l2a_is_l2_fill=0, perf_restart_preempt=1.
//    - No queue count changes that cycle.
//  - Restart load with l2bi_collided_miss=1 -> l2a_is_l2_fill=0.
//    Same with collided_miss=0 -> l2a_is_l2_fill=1.
//  - Assert reset with 3 queued entries -> l2a_request_valid=0 and all l2_ready=1 immediately;
//    nothing issues after release.

Source files
------------

// File: rtl/l2_cache_arb_stage_mq_if.sv
// Request-side bundle of the L2 arbiter stage: core queues in, bus-interface restarts in,
// issued request out toward the tag stage.
interface l2_cache_arb_stage_mq_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int REQ_W          = 40,
    parameter int LINE_W         = 512
);
    logic [NUM_REQUESTERS-1:0] l2i_request_valid;
    logic [REQ_W-1:0]          l2i_request [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0] l2_ready;

    logic                      l2bi_request_valid;
    logic [REQ_W-1:0]          l2bi_request;
    logic [LINE_W-1:0]         l2bi_data_from_memory;
    logic                      l2bi_stall;
    logic                      l2bi_collided_miss;

    logic                      l2a_request_valid;
    logic [REQ_W-1:0]          l2a_request;
    logic [LINE_W-1:0]         l2a_data_from_memory;
    logic                      l2a_is_l2_fill;
    logic                      l2a_is_restarted_flush;
    logic                      perf_restart_preempt;

    modport master (
        output l2i_request_valid, l2i_request,
        input  l2_ready,
        output l2bi_request_valid, l2bi_request, l2bi_data_from_memory,
        output l2bi_stall, l2bi_collided_miss,
        input  l2a_request_valid, l2a_request, l2a_data_from_memory,
        input  l2a_is_l2_fill, l2a_is_restarted_flush, perf_restart_preempt
    );

    modport slave (
        input  l2i_request_valid, l2i_request,
        output l2_ready,
        input  l2bi_request_valid, l2bi_request, l2bi_data_from_memory,
        input  l2bi_stall, l2bi_collided_miss,
        output l2a_request_valid, l2a_request, l2a_data_from_memory,
        output l2a_is_l2_fill, l2a_is_restarted_flush, perf_restart_preempt
    );
endinterface

// File: rtl/l2_cache_arb_stage_mq.sv
// L2 arbiter stage: per-core request FIFOs, round-robin grant over queue heads,
// restarted requests from the bus interface always take the issue slot.
module l2_cache_arb_stage_mq #(
    parameter int NUM_REQUESTERS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REQ_W          = 40,
    parameter int LINE_W         = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    l2_cache_arb_stage_mq_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    // Request type lives in the top three bits of a packet.
    localparam logic [2:0] L2REQ_FLUSH       = 3'd2;
    localparam logic [2:0] L2REQ_IINVALIDATE = 3'd3;
    localparam logic [2:0] L2REQ_DINVALIDATE = 3'd4;

    logic [REQ_W-1:0]          r_fifo   [NUM_REQUESTERS][FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr [NUM_REQUESTERS];
    logic [PTR_W-1:0]          r_rd_ptr [NUM_REQUESTERS];
    logic [CNT_W-1:0]          r_count  [NUM_REQUESTERS];
    logic [IDX_W-1:0]          r_rr_ptr;

    logic                      r_l2a_valid;
    logic [REQ_W-1:0]          r_l2a_request;
    logic [LINE_W-1:0]         r_l2a_data;
    logic                      r_l2a_fill;
    logic                      r_l2a_flush;
    logic                      r_perf_preempt;

    logic [NUM_REQUESTERS-1:0] w_ready;
    logic [NUM_REQUESTERS-1:0] w_nonempty;
    logic [NUM_REQUESTERS-1:0] w_push;
    logic [NUM_REQUESTERS-1:0] w_pop;
    logic                      w_grant_valid;
    logic [IDX_W-1:0]          w_grant_idx;
    logic                      w_issue_core;
    logic [REQ_W-1:0]          w_head;
    logic [2:0]                w_restart_type;

    // Ready is a function of queue occupancy only, so a core may gate valid on it.
    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            w_nonempty[i] = (r_count[i] != '0);
            w_ready[i]    = (r_count[i] != CNT_W'(FIFO_DEPTH));
            w_push[i]     = bus.l2i_request_valid[i] && w_ready[i];
        end
    end

    assign bus.l2_ready = w_ready;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        // Walk from farthest to nearest so the first non-empty queue after the pointer wins.
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            if (w_nonempty[(int'(r_rr_ptr) + k) % NUM_REQUESTERS]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQUESTERS);
            end
        end
    end

    assign w_restart_type = bus.l2bi_request[REQ_W-1 -: 3];
    assign w_issue_core   = !bus.l2bi_request_valid && !bus.l2bi_stall && w_grant_valid;
    assign w_head         = r_fifo[w_grant_idx][r_rd_ptr[w_grant_idx]];

    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            w_pop[i] = w_issue_core && (w_grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr <= IDX_W'(NUM_REQUESTERS - 1);
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
            if (w_issue_core) r_rr_ptr <= w_grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (w_push[i]) r_fifo[i][r_wr_ptr[i]] <= bus.l2i_request[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l2a_valid    <= 1'b0;
            r_l2a_fill     <= 1'b0;
            r_l2a_flush    <= 1'b0;
            r_perf_preempt <= 1'b0;
        end else begin
            r_l2a_valid    <= bus.l2bi_request_valid || w_issue_core;
            r_l2a_fill     <= bus.l2bi_request_valid && !bus.l2bi_collided_miss
                              && (w_restart_type != L2REQ_FLUSH);
            r_l2a_flush    <= bus.l2bi_request_valid && (w_restart_type == L2REQ_FLUSH);
            r_perf_preempt <= bus.l2bi_request_valid && (|w_nonempty);
        end
    end

    // Issued packet and fill data carry no reset; l2a_request holds when nothing issues.
    always_ff @(posedge clk) begin
        if (bus.l2bi_request_valid)
            r_l2a_request <= bus.l2bi_request;
        else if (w_issue_core)
            r_l2a_request <= w_head;
        r_l2a_data <= bus.l2bi_data_from_memory;
    end

    assign bus.l2a_request_valid      = r_l2a_valid;
    assign bus.l2a_request            = r_l2a_request;
    assign bus.l2a_data_from_memory   = r_l2a_data;
    assign bus.l2a_is_l2_fill         = r_l2a_fill;
    assign bus.l2a_is_restarted_flush = r_l2a_flush;
    assign bus.perf_restart_preempt   = r_perf_preempt;

    generate
        for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_q_chk
            a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                !(w_push[g] && (r_count[g] == CNT_W'(FIFO_DEPTH))));
        end
    endgenerate

    a_restart_type: assert property (@(posedge clk) disable iff (reset)
        bus.l2bi_request_valid |-> ((w_restart_type != L2REQ_IINVALIDATE)
                                    && (w_restart_type != L2REQ_DINVALIDATE)));
endmodule

// File: tb/tb_l2_cache_arb_stage_mq.sv
// Directed bench for l2_cache_arb_stage_mq: queue fill/drain, round-robin order,
// restart priority and flags, asynchronous reset flush.
module tb_l2_cache_arb_stage_mq;
    localparam int N      = 4;
    localparam int REQ_W  = 40;
    localparam int LINE_W = 512;

    localparam logic [2:0] T_LOAD  = 3'd0;
    localparam logic [2:0] T_STORE = 3'd1;
    localparam logic [2:0] T_FLUSH = 3'd2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    l2_cache_arb_stage_mq_if #(.NUM_REQUESTERS(N), .REQ_W(REQ_W), .LINE_W(LINE_W)) bus ();

    l2_cache_arb_stage_mq #(
        .NUM_REQUESTERS(N), .FIFO_DEPTH(4), .REQ_W(REQ_W), .LINE_W(LINE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [REQ_W-1:0] mk(input logic [2:0] t, input logic [7:0] id);
        return {t, 29'd0, id};
    endfunction

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.l2i_request_valid     = '0;
        for (int c = 0; c < N; c++) bus.l2i_request[c] = '0;
        bus.l2bi_request_valid    = 1'b0;
        bus.l2bi_request          = '0;
        bus.l2bi_data_from_memory = '0;
        bus.l2bi_stall            = 1'b0;
        bus.l2bi_collided_miss    = 1'b0;

        repeat (2) tick();
        check_eq("rst_valid", bus.l2a_request_valid, 0);
        check_eq("rst_ready", bus.l2_ready, 4'hF);
        check_eq("rst_fill", bus.l2a_is_l2_fill, 0);
        check_eq("rst_flush", bus.l2a_is_restarted_flush, 0);
        check_eq("rst_perf", bus.perf_restart_preempt, 0);
        #2 reset = 1'b0;
        tick();

        // Single push on core 0: two-edge latency
        bus.l2i_request_valid[0] = 1'b1;
        bus.l2i_request[0] = mk(T_LOAD, 8'hA1);
        tick();
        bus.l2i_request_valid[0] = 1'b0;
        check_eq("t1_nobypass", bus.l2a_request_valid, 0);
        check_eq("t1_ready0", bus.l2_ready[0], 1);
        tick();
        check_eq("t1_valid", bus.l2a_request_valid, 1);
        check_eq("t1_req", bus.l2a_request, mk(T_LOAD, 8'hA1));
        check_eq("t1_fill", bus.l2a_is_l2_fill, 0);
        check_eq("t1_flush", bus.l2a_is_restarted_flush, 0);
        tick();
        check_eq("t1_idle", bus.l2a_request_valid, 0);

        // Fill core 2 under stall, then drain in order
        bus.l2bi_stall = 1'b1;
        for (int e = 0; e < 4; e++) begin
            bus.l2i_request_valid[2] = 1'b1;
            bus.l2i_request[2] = mk(T_STORE, 8'h20 + 8'(e));
            tick();
            check_eq($sformatf("t2_ready_%0d", e), bus.l2_ready[2], (e == 3) ? 1'b0 : 1'b1);
        end
        bus.l2i_request_valid[2] = 1'b0;
        check_eq("t2_stalled", bus.l2a_request_valid, 0);
        bus.l2bi_stall = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            check_eq($sformatf("t2_valid_%0d", e), bus.l2a_request_valid, 1);
            check_eq($sformatf("t2_req_%0d", e), bus.l2a_request, mk(T_STORE, 8'h20 + 8'(e)));
            if (e == 0) check_eq("t2_ready_after_pop", bus.l2_ready[2], 1);
        end
        tick();
        check_eq("t2_idle", bus.l2a_request_valid, 0);

        // Reset restores the RR pointer, then 2 entries per core drain round-robin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        bus.l2bi_stall = 1'b1;
        for (int e = 0; e < 2; e++) begin
            for (int c = 0; c < N; c++) begin
                bus.l2i_request_valid[c] = 1'b1;
                bus.l2i_request[c] = mk(T_LOAD, 8'(c * 16 + e));
            end
            tick();
        end
        bus.l2i_request_valid = '0;
        bus.l2bi_stall = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            check_eq($sformatf("t3_valid_%0d", n), bus.l2a_request_valid, 1);
            check_eq($sformatf("t3_req_%0d", n), bus.l2a_request, mk(T_LOAD, 8'((n % 4) * 16 + n / 4)));
        end
        tick();
        check_eq("t3_idle", bus.l2a_request_valid, 0);

        // Restart flush preempts non-empty queues without popping them
        bus.l2bi_stall = 1'b1;
        bus.l2i_request_valid[1] = 1'b1;
        bus.l2i_request[1] = mk(T_LOAD, 8'h51);
        bus.l2i_request_valid[3] = 1'b1;
        bus.l2i_request[3] = mk(T_STORE, 8'h73);
        tick();
        bus.l2i_request_valid = '0;
        bus.l2bi_stall = 1'b0;
        bus.l2bi_request_valid = 1'b1;
        bus.l2bi_request = mk(T_FLUSH, 8'hF0);
        bus.l2bi_collided_miss = 1'b0;
        tick();
        check_eq("t4_valid", bus.l2a_request_valid, 1);
        check_eq("t4_req", bus.l2a_request, mk(T_FLUSH, 8'hF0));
        check_eq("t4_flush", bus.l2a_is_restarted_flush, 1);
        check_eq("t4_fill", bus.l2a_is_l2_fill, 0);
        check_eq("t4_perf", bus.perf_restart_preempt, 1);
        bus.l2bi_request_valid = 1'b0;
        tick();
        check_eq("t4_core1", bus.l2a_request, mk(T_LOAD, 8'h51));
        check_eq("t4_core1_flush", bus.l2a_is_restarted_flush, 0);
        check_eq("t4_core1_perf", bus.perf_restart_preempt, 0);
        tick();
        check_eq("t4_core3", bus.l2a_request, mk(T_STORE, 8'h73));
        check_eq("t4_core3_valid", bus.l2a_request_valid, 1);
        tick();
        check_eq("t4_idle", bus.l2a_request_valid, 0);

        // Restart loads: collided miss suppresses the fill flag
        bus.l2bi_request_valid = 1'b1;
        bus.l2bi_request = mk(T_LOAD, 8'hC1);
        bus.l2bi_collided_miss = 1'b1;
        bus.l2bi_data_from_memory = {16{32'hDEADBEEF}};
        tick();
        check_eq("t5_valid", bus.l2a_request_valid, 1);
        check_eq("t5_fill_collided", bus.l2a_is_l2_fill, 0);
        check_eq("t5_flush", bus.l2a_is_restarted_flush, 0);
        check_eq("t5_perf_empty", bus.perf_restart_preempt, 0);
        check_eq("t5_data1", bus.l2a_data_from_memory, {16{32'hDEADBEEF}});
        bus.l2bi_collided_miss = 1'b0;
        bus.l2bi_request = mk(T_LOAD, 8'hC2);
        bus.l2bi_data_from_memory = {16{32'h12345678}};
        tick();
        check_eq("t5_fill", bus.l2a_is_l2_fill, 1);
        check_eq("t5_req", bus.l2a_request, mk(T_LOAD, 8'hC2));
        check_eq("t5_data2", bus.l2a_data_from_memory, {16{32'h12345678}});
        bus.l2bi_request_valid = 1'b0;
        tick();
        check_eq("t5_fill_off", bus.l2a_is_l2_fill, 0);
        check_eq("t5_idle", bus.l2a_request_valid, 0);

        // Reset with three queued entries discards them immediately
        bus.l2bi_stall = 1'b1;
        for (int e = 0; e < 3; e++) begin
            bus.l2i_request_valid[0] = 1'b1;
            bus.l2i_request[0] = mk(T_LOAD, 8'h60 + 8'(e));
            tick();
        end
        bus.l2i_request_valid[0] = 1'b0;
        check_eq("t6_ready0", bus.l2_ready[0], 1);
        bus.l2bi_request_valid = 1'b1;
        bus.l2bi_request = mk(T_STORE, 8'hD1);
        tick();
        bus.l2bi_request_valid = 1'b0;
        check_eq("t6_restart_valid", bus.l2a_request_valid, 1);
        check_eq("t6_restart_perf", bus.perf_restart_preempt, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_valid", bus.l2a_request_valid, 0);
        check_eq("t6_rst_ready", bus.l2_ready, 4'hF);
        check_eq("t6_rst_perf", bus.perf_restart_preempt, 0);
        #2 reset = 1'b0;
        bus.l2bi_stall = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check_eq($sformatf("t6_no_issue_%0d", n), bus.l2a_request_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
